timer_multi: RTL and testbench
==============================

# timer_multi

Multi-channel memory-mapped timer for the simple system. It replaces the single-compare timer as the `Timer` bus device at 0x30000. It provides one free-running counter with a prescaler and `NumChannels` independent compare channels, each with optional periodic auto-reload. Per-channel interrupt status and enable bits are combined into one interrupt output that drives the core's `irq_timer_i`.

## Interface
- `NumChannels`, 4: compare channels, legal range 1..8.
- `DataWidth`, 32: bus data width.
- `AddressWidth`, 32: bus address width; only bits [9:0] are decoded.
- `CounterWidth`, 64: counter and compare width, legal range DataWidth+1..2*DataWidth; unused HI bits read 0.
- `PrescaleWidth`, 12: width of the prescaler register.
- `clk_i` in 1: system clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `timer_req_i` in 1: bus request; always granted.
- `timer_we_i` in 1: write enable.
- `timer_be_i` in DataWidth/8: byte enables; honoured on every writable field.
- `timer_addr_i` in AddressWidth: byte address.
- `timer_wdata_i` in DataWidth: write data.
- `timer_rvalid_o` out 1: response valid.
- `timer_rdata_o` out DataWidth: read data; 0 on writes and on errors.
- `timer_err_o` out 1: error response, qualified by `timer_rvalid_o`.
- `timer_intr_o` out 1: OR of `INTR_STATE & INTR_ENABLE`.

## Operation
- Register map (word offsets):
  - 0x000 `CTRL`: bit0 enable.
  - 0x004 `PRESCALE`.
  - 0x008 `MTIME_LO`, 0x00C `MTIME_HI`.
  - 0x010 `INTR_STATE` (W1C, bits [NumChannels-1:0]).
  - 0x014 `INTR_ENABLE`.
  - Channel n at 0x100+0x10*n: +0 `CMP_LO`, +4 `CMP_HI`, +8 `PERIOD` (DataWidth), +C `CFG` (bit0 periodic).
- Error cases: unmapped offsets, channel index ≥ NumChannels, and misaligned addresses give `err`=1. The write is dropped and rdata is 0.
- Prescaler: internal count `pcnt` runs while enabled. When `pcnt`==`PRESCALE`, `pcnt` goes to 0 and mtime increments. `PRESCALE`=0 means an increment every cycle.
- mtime wraps from 2^CounterWidth-1 to 0.
- A write to either mtime half loads that half and clears `pcnt`. An increment does not occur in that cycle.
- Hit for channel n: `mtime >= cmp[n]`, unsigned, evaluated on the registered values every cycle.
- One-shot mode (`CFG`.periodic=0): a hit sets `INTR_STATE[n]` every cycle while true (level-sticky).
- Periodic mode: a hit sets `INTR_STATE[n]` and performs `cmp[n] += PERIOD`, zero-extended, modulo 2^CounterWidth. If `PERIOD`=0, the channel behaves as one-shot.
- Simultaneous events:
  - Hardware set and W1C clear of the same `INTR_STATE` bit: set wins.
  - SW write to `CMP_*` in the same cycle as a periodic reload: the SW value wins and no reload occurs. `INTR_STATE` is still set.
  - Write to `INTR_ENABLE` takes effect on `timer_intr_o` the next cycle.
- Disabled (`CTRL`.enable=0): mtime and `pcnt` hold. Hits are still evaluated.

## Timing
- Reset values (`rst_i` sampled high at a rising edge): all registers 0, except `CMP_*`, which reset to all ones. Every output is 0 after reset.
- No spurious hit after reset: the all-ones `CMP_*` value does not match until mtime reaches it.
- Bus response: `timer_rvalid_o` is asserted exactly 1 cycle after `timer_req_i`. Back-to-back requests are supported at one per cycle.
- Read data and err are registered and valid with rvalid.
- Write effect: a register written in cycle t shows its new value from t+1. A read in t+1 returns it.
- Hit to `INTR_STATE`: 1 cycle, measured from the cycle mtime reaches the compare value. `timer_intr_o` follows `INTR_STATE` in the same cycle (combinational from registers, no path from bus inputs).
- Reset mid-transaction: the pending rvalid is dropped and no response is issued.

## Configuration
- `TIMER_MULTI_PERIODIC_EN` defined: periodic mode and `PERIOD` registers are implemented.
- `TIMER_MULTI_PERIODIC_EN` undefined:
  - `PERIOD` and `CFG` read 0, and writes to them are accepted without err and ignored.
  - All channels are one-shot.
  - The reload adders are not synthesised.

## Test plan
- Reset, then read every register: CTRL=0, mtime=0, `CMP_LO`/`CMP_HI`=0xFFFF_FFFF, err=0. `timer_intr_o`=0. Read of 0x3F0 gives err=1, rdata=0.
- `PRESCALE`=3, enable, wait 40 cycles: mtime=10±1. Write `MTIME_LO`=0xFFFF_FFFF, `MTIME_HI`=0 → after 4 cycles `MTIME_HI`=1, `MTIME_LO`=0.
- Ch0 `CMP`=100, `INTR_ENABLE`=1, `PRESCALE`=0: intr rises in the cycle after mtime=100. W1C 0x1 while mtime>100 → bit stays 1. Write `CMP_HI`=0xFFFF_FFFF, then W1C → intr=0.
- Ch1 periodic, `CMP`=50, `PERIOD`=20: `INTR_STATE[1]` set at mtime 50, 70, 90 with W1C between. `CMP` reads 110 after the third hit.
- Ch2 periodic, `CMP`=2^64-10, `PERIOD`=16, mtime preloaded near the top: the reload wraps `CMP` to 6. W1C and a hit in the same cycle → bit remains 1.
- Build without `TIMER_MULTI_PERIODIC_EN`: `PERIOD` write 20 reads 0. Ch1 one-shot stays set at 50 and `CMP` is unchanged.

Source files
------------

// File: rtl/timer_multi.sv
// timer_multi: memory-mapped timer with a prescaled free-running counter and
// NumChannels compare channels. Define TIMER_MULTI_PERIODIC_EN for periodic auto-reload.
module timer_multi #(
    parameter int unsigned NumChannels   = 4,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned CounterWidth  = 64,
    parameter int unsigned PrescaleWidth = 12
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    timer_req_i,
    input  logic                    timer_we_i,
    input  logic [DataWidth/8-1:0]  timer_be_i,
    input  logic [AddressWidth-1:0] timer_addr_i,
    input  logic [DataWidth-1:0]    timer_wdata_i,
    output logic                    timer_rvalid_o,
    output logic [DataWidth-1:0]    timer_rdata_o,
    output logic                    timer_err_o,
    output logic                    timer_intr_o
);

    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned HiWidth = CounterWidth - DataWidth;

    logic                     r_ctrl_en;
    logic [PrescaleWidth-1:0] r_prescale;
    logic [PrescaleWidth-1:0] r_pcnt;
    logic [CounterWidth-1:0]  r_mtime;
    logic [NumChannels-1:0]   r_intr_state;
    logic [NumChannels-1:0]   r_intr_enable;
    logic [CounterWidth-1:0]  r_cmp [NumChannels];
`ifdef TIMER_MULTI_PERIODIC_EN
    logic [DataWidth-1:0]     r_period [NumChannels];
    logic [NumChannels-1:0]   r_cfg_periodic;
    logic [NumChannels-1:0]   w_reload;
    logic [NumChannels-1:0]   w_wr_period;
    logic [NumChannels-1:0]   w_wr_cfg;
    logic [DataWidth-1:0]     w_period_rd;
    logic                     w_cfg_rd;
`else
    logic                     w_unused_sel;
`endif

    logic [9:0]              w_addr;
    logic [3:0]              w_chan_idx;
    logic                    w_chan_ok;
    logic [DataWidth-1:0]    w_be_mask;
    logic                    w_map_ok;
    logic                    w_wr;
    logic                    w_sel_ctrl;
    logic                    w_sel_prescale;
    logic                    w_sel_mtime_lo;
    logic                    w_sel_mtime_hi;
    logic                    w_sel_istate;
    logic                    w_sel_ienable;
    logic                    w_sel_cmp_lo;
    logic                    w_sel_cmp_hi;
    logic                    w_sel_period;
    logic                    w_sel_cfg;
    logic [NumChannels-1:0]  w_wr_cmp_lo;
    logic [NumChannels-1:0]  w_wr_cmp_hi;
    logic [NumChannels-1:0]  w_hit;
    logic [NumChannels-1:0]  w_w1c;
    logic [CounterWidth-1:0] w_cmp_rd;
    logic [DataWidth-1:0]    w_rdata;
    logic                    w_unused_addr;

    function automatic logic [DataWidth-1:0] f_merge(input logic [DataWidth-1:0] old_v,
                                                     input logic [DataWidth-1:0] new_v,
                                                     input logic [DataWidth-1:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign w_addr        = timer_addr_i[9:0];
    assign w_chan_idx    = w_addr[7:4];
    assign w_chan_ok     = 32'(w_chan_idx) < NumChannels;
    assign w_unused_addr = ^timer_addr_i[AddressWidth-1:10];

    for (genvar b = 0; b < BeWidth; b++) begin : g_be
        assign w_be_mask[8*b +: 8] = {8{timer_be_i[b]}};
    end

    // Address decode: misaligned, unmapped and out-of-range channel accesses are errors.
    always_comb begin
        w_map_ok       = 1'b0;
        w_sel_ctrl     = 1'b0;
        w_sel_prescale = 1'b0;
        w_sel_mtime_lo = 1'b0;
        w_sel_mtime_hi = 1'b0;
        w_sel_istate   = 1'b0;
        w_sel_ienable  = 1'b0;
        w_sel_cmp_lo   = 1'b0;
        w_sel_cmp_hi   = 1'b0;
        w_sel_period   = 1'b0;
        w_sel_cfg      = 1'b0;
        if (w_addr[1:0] == 2'b00) begin
            if (w_addr[9:8] == 2'b00) begin
                w_map_ok = 1'b1;
                case (w_addr[7:2])
                    6'd0:    w_sel_ctrl     = 1'b1;
                    6'd1:    w_sel_prescale = 1'b1;
                    6'd2:    w_sel_mtime_lo = 1'b1;
                    6'd3:    w_sel_mtime_hi = 1'b1;
                    6'd4:    w_sel_istate   = 1'b1;
                    6'd5:    w_sel_ienable  = 1'b1;
                    default: w_map_ok       = 1'b0;
                endcase
            end else if (w_addr[9:8] == 2'b01 && w_chan_ok) begin
                w_map_ok = 1'b1;
                case (w_addr[3:2])
                    2'd0:    w_sel_cmp_lo = 1'b1;
                    2'd1:    w_sel_cmp_hi = 1'b1;
                    2'd2:    w_sel_period = 1'b1;
                    default: w_sel_cfg    = 1'b1;
                endcase
            end
        end
    end

    assign w_wr  = timer_req_i & timer_we_i & w_map_ok;
    assign w_w1c = (w_wr && w_sel_istate) ? NumChannels'(timer_wdata_i & w_be_mask) : '0;

    // Per-channel write strobes, read selection and hit detection.
    always_comb begin
        w_wr_cmp_lo = '0;
        w_wr_cmp_hi = '0;
        w_cmp_rd    = '0;
        w_hit       = '0;
`ifdef TIMER_MULTI_PERIODIC_EN
        w_wr_period = '0;
        w_wr_cfg    = '0;
        w_period_rd = '0;
        w_cfg_rd    = 1'b0;
        w_reload    = '0;
`endif
        for (int n = 0; n < NumChannels; n++) begin
            w_hit[n] = r_mtime >= r_cmp[n];
`ifdef TIMER_MULTI_PERIODIC_EN
            w_reload[n] = w_hit[n] & r_cfg_periodic[n] & (|r_period[n]);
`endif
            if (w_chan_idx == 4'(n)) begin
                w_wr_cmp_lo[n] = w_wr & w_sel_cmp_lo;
                w_wr_cmp_hi[n] = w_wr & w_sel_cmp_hi;
                w_cmp_rd       = r_cmp[n];
`ifdef TIMER_MULTI_PERIODIC_EN
                w_wr_period[n] = w_wr & w_sel_period;
                w_wr_cfg[n]    = w_wr & w_sel_cfg;
                w_period_rd    = r_period[n];
                w_cfg_rd       = r_cfg_periodic[n];
`endif
            end
        end
    end

    // Read data multiplexer; unimplemented high bits read as zero.
    always_comb begin
        w_rdata = '0;
        if (w_sel_ctrl)          w_rdata = DataWidth'(r_ctrl_en);
        else if (w_sel_prescale) w_rdata = DataWidth'(r_prescale);
        else if (w_sel_mtime_lo) w_rdata = r_mtime[DataWidth-1:0];
        else if (w_sel_mtime_hi) w_rdata = DataWidth'(r_mtime[CounterWidth-1:DataWidth]);
        else if (w_sel_istate)   w_rdata = DataWidth'(r_intr_state);
        else if (w_sel_ienable)  w_rdata = DataWidth'(r_intr_enable);
        else if (w_sel_cmp_lo)   w_rdata = w_cmp_rd[DataWidth-1:0];
        else if (w_sel_cmp_hi)   w_rdata = DataWidth'(w_cmp_rd[CounterWidth-1:DataWidth]);
`ifdef TIMER_MULTI_PERIODIC_EN
        else if (w_sel_period)   w_rdata = w_period_rd;
        else if (w_sel_cfg)      w_rdata = DataWidth'(w_cfg_rd);
`endif
    end

`ifndef TIMER_MULTI_PERIODIC_EN
    assign w_unused_sel = w_sel_period | w_sel_cfg;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_rvalid_o <= 1'b0;
            timer_err_o    <= 1'b0;
            timer_rdata_o  <= '0;
        end else begin
            timer_rvalid_o <= timer_req_i;
            timer_err_o    <= timer_req_i & ~w_map_ok;
            timer_rdata_o  <= (timer_req_i && !timer_we_i && w_map_ok) ? w_rdata : '0;
        end
    end

    // Register file, prescaler, counter and channel state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ctrl_en     <= 1'b0;
            r_prescale    <= '0;
            r_pcnt        <= '0;
            r_mtime       <= '0;
            r_intr_state  <= '0;
            r_intr_enable <= '0;
            for (int n = 0; n < NumChannels; n++) begin
                r_cmp[n] <= '1;
`ifdef TIMER_MULTI_PERIODIC_EN
                r_period[n] <= '0;
`endif
            end
`ifdef TIMER_MULTI_PERIODIC_EN
            r_cfg_periodic <= '0;
`endif
        end else begin
            if (w_wr && w_sel_ctrl && timer_be_i[0]) begin
                r_ctrl_en <= timer_wdata_i[0];
            end
            if (w_wr && w_sel_prescale) begin
                r_prescale <= PrescaleWidth'(f_merge(DataWidth'(r_prescale), timer_wdata_i, w_be_mask));
            end
            if (w_wr && w_sel_ienable) begin
                r_intr_enable <= NumChannels'(f_merge(DataWidth'(r_intr_enable), timer_wdata_i,
                                                      w_be_mask));
            end
            // Hardware set takes priority over a simultaneous W1C.
            r_intr_state <= (r_intr_state & ~w_w1c) | w_hit;

            // A software load of either half restarts the prescaler and suppresses the tick.
            if (w_wr && (w_sel_mtime_lo || w_sel_mtime_hi)) begin
                r_pcnt <= '0;
                if (w_sel_mtime_lo) begin
                    r_mtime[DataWidth-1:0] <= f_merge(r_mtime[DataWidth-1:0], timer_wdata_i,
                                                      w_be_mask);
                end else begin
                    r_mtime[CounterWidth-1:DataWidth] <= HiWidth'(f_merge(
                        DataWidth'(r_mtime[CounterWidth-1:DataWidth]), timer_wdata_i, w_be_mask));
                end
            end else if (r_ctrl_en) begin
                if (r_pcnt == r_prescale) begin
                    r_pcnt  <= '0;
                    r_mtime <= r_mtime + CounterWidth'(1);
                end else begin
                    r_pcnt <= r_pcnt + PrescaleWidth'(1);
                end
            end

            for (int n = 0; n < NumChannels; n++) begin
`ifdef TIMER_MULTI_PERIODIC_EN
                if (w_wr_period[n]) begin
                    r_period[n] <= f_merge(r_period[n], timer_wdata_i, w_be_mask);
                end
                if (w_wr_cfg[n] && timer_be_i[0]) begin
                    r_cfg_periodic[n] <= timer_wdata_i[0];
                end
`endif
                if (w_wr_cmp_lo[n] || w_wr_cmp_hi[n]) begin
                    if (w_wr_cmp_lo[n]) begin
                        r_cmp[n][DataWidth-1:0] <= f_merge(r_cmp[n][DataWidth-1:0],
                                                           timer_wdata_i, w_be_mask);
                    end
                    if (w_wr_cmp_hi[n]) begin
                        r_cmp[n][CounterWidth-1:DataWidth] <= HiWidth'(f_merge(
                            DataWidth'(r_cmp[n][CounterWidth-1:DataWidth]), timer_wdata_i,
                            w_be_mask));
                    end
                end
`ifdef TIMER_MULTI_PERIODIC_EN
                else if (w_reload[n]) begin
                    r_cmp[n] <= r_cmp[n] + CounterWidth'(r_period[n]);
                end
`endif
            end
        end
    end

    assign timer_intr_o = |(r_intr_state & r_intr_enable);

endmodule

// File: tb/tb_timer_multi.sv
// Directed self-checking bench for timer_multi; periodic scenarios are compiled
// when TIMER_MULTI_PERIODIC_EN is defined, the one-shot-only scenario otherwise.
module tb_timer_multi;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        intr;

    int          n_cmp;
    int          n_bad;
    logic        got_rv;
    logic        got_err;
    logic [31:0] got_rd;

    timer_multi dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .timer_req_i   (req),
        .timer_we_i    (we),
        .timer_be_i    (be),
        .timer_addr_i  (addr),
        .timer_wdata_i (wdata),
        .timer_rvalid_o(rvalid),
        .timer_rdata_o (rdata),
        .timer_err_o   (err),
        .timer_intr_o  (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus transaction: drive at a falling edge, capture the response one cycle later.
    task automatic bus_op(input logic w, input logic [9:0] a, input logic [31:0] d,
                          input logic [3:0] b);
        req   = 1'b1;
        we    = w;
        addr  = 32'(a);
        wdata = d;
        be    = b;
        @(negedge clk);
        got_rv  = rvalid;
        got_rd  = rdata;
        got_err = err;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        be    = '0;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        bus_op(1'b1, a, d, 4'hF);
    endtask

    task automatic rd(input logic [9:0] a);
        bus_op(1'b0, a, 32'h0, 4'hF);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0]  a;
        logic [31:0] exp;
        logic [9:0]  bad_addr [6];
        bad_addr = '{10'h3F0, 10'h002, 10'h140, 10'h018, 10'h0FC, 10'h201};
        do_reset();
        n_cmp++;
        if (rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 || intr !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: rvalid=%b err=%b rdata=%h intr=%b want all 0",
                     rvalid, err, rdata, intr);
        end
        for (int g = 0; g < 6; g++) begin
            a = 10'(4 * g);
            rd(a);
            n_cmp++;
            if (got_rv !== 1'b1 || got_err !== 1'b0 || got_rd !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_global[%h]: rv=%b err=%b rdata=%h want 1 0 00000000",
                         a, got_rv, got_err, got_rd);
            end
        end
        for (int ch = 0; ch < 4; ch++) begin
            for (int off = 0; off < 4; off++) begin
                a   = 10'(32'h100 + 16 * ch + 4 * off);
                exp = (off < 2) ? 32'hFFFF_FFFF : 32'h0;
                rd(a);
                n_cmp++;
                if (got_rv !== 1'b1 || got_err !== 1'b0 || got_rd !== exp) begin
                    n_bad++;
                    $display("FAIL reset_chan[%h]: rv=%b err=%b rdata=%h want 1 0 %h",
                             a, got_rv, got_err, got_rd, exp);
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            rd(bad_addr[i]);
            n_cmp++;
            if (got_rv !== 1'b1 || got_err !== 1'b1 || got_rd !== 32'h0) begin
                n_bad++;
                $display("FAIL err_read[%h]: rv=%b err=%b rdata=%h want 1 1 00000000",
                         bad_addr[i], got_rv, got_err, got_rd);
            end
        end
        bus_op(1'b1, 10'h001, 32'h1, 4'hF);
        rd(10'h000);
        n_cmp++;
        if (got_rd !== 32'h0) begin
            n_bad++;
            $display("FAIL err_write_dropped: CTRL=%h want 00000000", got_rd);
        end
    endtask

    task automatic test_prescale();
        do_reset();
        wr(10'h004, 32'd3);
        wr(10'h000, 32'd1);
        idle(40);
        rd(10'h008);
        n_cmp++;
        if (got_rd < 32'd9 || got_rd > 32'd11) begin
            n_bad++;
            $display("FAIL prescale_count: mtime_lo=%0d want 10+-1", got_rd);
        end
        wr(10'h008, 32'hFFFF_FFFF);
        wr(10'h00C, 32'h0);
        idle(4);
        rd(10'h00C);
        n_cmp++;
        if (got_rd !== 32'h1) begin
            n_bad++;
            $display("FAIL carry_hi: mtime_hi=%h want 00000001", got_rd);
        end
        rd(10'h008);
        n_cmp++;
        if (got_rd !== 32'h0) begin
            n_bad++;
            $display("FAIL carry_lo: mtime_lo=%h want 00000000", got_rd);
        end
        wr(10'h000, 32'h0);
        bus_op(1'b1, 10'h000, 32'h1, 4'h0);
        bus_op(1'b1, 10'h004, 32'h0000_0FFF, 4'h1);
        wr(10'h008, 32'd5);
        wr(10'h00C, 32'd0);
        idle(10);
        rd(10'h008);
        n_cmp++;
        if (got_rd !== 32'd5) begin
            n_bad++;
            $display("FAIL disabled_hold: mtime_lo=%h want 00000005", got_rd);
        end
        rd(10'h000);
        n_cmp++;
        if (got_rd !== 32'h0) begin
            n_bad++;
            $display("FAIL ctrl_be_zero: CTRL=%h want 00000000", got_rd);
        end
        rd(10'h004);
        n_cmp++;
        if (got_rd !== 32'h0000_00FF) begin
            n_bad++;
            $display("FAIL prescale_be: PRESCALE=%h want 000000ff", got_rd);
        end
    endtask

    task automatic test_compare();
        do_reset();
        wr(10'h100, 32'd100);
        wr(10'h104, 32'd0);
        wr(10'h014, 32'h1);
        wr(10'h000, 32'h1);
        idle(100);
        n_cmp++;
        if (intr !== 1'b0) begin
            n_bad++;
            $display("FAIL cmp_early: intr=%b want 0 at mtime=100", intr);
        end
        idle(1);
        n_cmp++;
        if (intr !== 1'b1) begin
            n_bad++;
            $display("FAIL cmp_rise: intr=%b want 1 one cycle after mtime=100", intr);
        end
        wr(10'h010, 32'h1);
        rd(10'h010);
        n_cmp++;
        if (got_rd !== 32'h1) begin
            n_bad++;
            $display("FAIL cmp_sticky: INTR_STATE=%h want 00000001", got_rd);
        end
        wr(10'h014, 32'h0);
        n_cmp++;
        if (intr !== 1'b0) begin
            n_bad++;
            $display("FAIL ienable_off: intr=%b want 0", intr);
        end
        wr(10'h014, 32'h1);
        n_cmp++;
        if (intr !== 1'b1) begin
            n_bad++;
            $display("FAIL ienable_on: intr=%b want 1", intr);
        end
        wr(10'h104, 32'hFFFF_FFFF);
        wr(10'h010, 32'h1);
        n_cmp++;
        if (intr !== 1'b0) begin
            n_bad++;
            $display("FAIL cmp_clear: intr=%b want 0", intr);
        end
        rd(10'h010);
        n_cmp++;
        if (got_rd !== 32'h0) begin
            n_bad++;
            $display("FAIL cmp_clear_state: INTR_STATE=%h want 00000000", got_rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [3];
        do_reset();
        wr(10'h014, 32'hA);
        n_cmp++;
        if (got_rv !== 1'b1 || got_rd !== 32'h0 || got_err !== 1'b0) begin
            n_bad++;
            $display("FAIL write_resp: rv=%b rdata=%h err=%b want 1 00000000 0",
                     got_rv, got_rd, got_err);
        end
        exp = '{32'hA, 32'h0000_0FFF, 32'hF};
        rd(10'h014);
        n_cmp++;
        if (got_rv !== 1'b1 || got_rd !== exp[0]) begin
            n_bad++;
            $display("FAIL b2b_read0: rv=%b rdata=%h want 1 %h", got_rv, got_rd, exp[0]);
        end
        wr(10'h004, 32'hFFFF_FFFF);
        rd(10'h004);
        n_cmp++;
        if (got_rv !== 1'b1 || got_rd !== exp[1]) begin
            n_bad++;
            $display("FAIL b2b_read1: rv=%b rdata=%h want 1 %h", got_rv, got_rd, exp[1]);
        end
        wr(10'h014, 32'hFF);
        rd(10'h014);
        n_cmp++;
        if (got_rv !== 1'b1 || got_rd !== exp[2]) begin
            n_bad++;
            $display("FAIL b2b_read2: rv=%b rdata=%h want 1 %h", got_rv, got_rd, exp[2]);
        end
        idle(1);
        n_cmp++;
        if (rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL rvalid_idle: rvalid=%b want 0", rvalid);
        end
        req = 1'b1; we = 1'b0; addr = 32'h14; be = 4'hF; rst = 1'b1;
        @(negedge clk);
        req = 1'b0; addr = '0; be = '0; rst = 1'b0;
        n_cmp++;
        if (rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_drop: rvalid=%b want 0", rvalid);
        end
    endtask

`ifdef TIMER_MULTI_PERIODIC_EN
    task automatic test_periodic();
        do_reset();
        wr(10'h110, 32'd50);
        wr(10'h114, 32'd0);
        wr(10'h118, 32'd20);
        wr(10'h11C, 32'd1);
        wr(10'h014, 32'h2);
        wr(10'h000, 32'h1);
        for (int k = 0; k < 3; k++) begin
            idle((k == 0) ? 50 : 18);
            n_cmp++;
            if (intr !== 1'b0) begin
                n_bad++;
                $display("FAIL periodic_pre[%0d]: intr=%b want 0", k, intr);
            end
            idle(1);
            n_cmp++;
            if (intr !== 1'b1) begin
                n_bad++;
                $display("FAIL periodic_hit[%0d]: intr=%b want 1", k, intr);
            end
            wr(10'h010, 32'h2);
            n_cmp++;
            if (intr !== 1'b0) begin
                n_bad++;
                $display("FAIL periodic_w1c[%0d]: intr=%b want 0", k, intr);
            end
        end
        rd(10'h110);
        n_cmp++;
        if (got_rd !== 32'd110) begin
            n_bad++;
            $display("FAIL periodic_cmp_lo: CMP_LO=%0d want 110", got_rd);
        end
        rd(10'h114);
        n_cmp++;
        if (got_rd !== 32'd0) begin
            n_bad++;
            $display("FAIL periodic_cmp_hi: CMP_HI=%h want 00000000", got_rd);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        wr(10'h128, 32'd16);
        wr(10'h12C, 32'd1);
        wr(10'h120, 32'hFFFF_FFF6);
        wr(10'h124, 32'hFFFF_FFFF);
        wr(10'h00C, 32'hFFFF_FFFF);
        wr(10'h008, 32'hFFFF_FFF6);
        rd(10'h120);
        n_cmp++;
        if (got_rd !== 32'hFFFF_FFF6) begin
            n_bad++;
            $display("FAIL wrap_before: CMP_LO=%h want fffffff6", got_rd);
        end
        rd(10'h120);
        n_cmp++;
        if (got_rd !== 32'd6) begin
            n_bad++;
            $display("FAIL wrap_lo: CMP_LO=%h want 00000006", got_rd);
        end
        rd(10'h124);
        n_cmp++;
        if (got_rd !== 32'h0) begin
            n_bad++;
            $display("FAIL wrap_hi: CMP_HI=%h want 00000000", got_rd);
        end
        rd(10'h120);
        n_cmp++;
        if (got_rd !== 32'd38) begin
            n_bad++;
            $display("FAIL wrap_next: CMP_LO=%0d want 38", got_rd);
        end
        wr(10'h010, 32'h4);
        rd(10'h010);
        n_cmp++;
        if (got_rd !== 32'h4) begin
            n_bad++;
            $display("FAIL set_beats_w1c: INTR_STATE=%h want 00000004", got_rd);
        end
        wr(10'h124, 32'hFFFF_FFFF);
        rd(10'h120);
        n_cmp++;
        if (got_rd !== 32'h56) begin
            n_bad++;
            $display("FAIL sw_beats_reload_lo: CMP_LO=%h want 00000056", got_rd);
        end
        rd(10'h124);
        n_cmp++;
        if (got_rd !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL sw_beats_reload_hi: CMP_HI=%h want ffffffff", got_rd);
        end
    endtask
`else
    task automatic test_oneshot_only();
        do_reset();
        wr(10'h110, 32'd50);
        wr(10'h114, 32'd0);
        wr(10'h118, 32'd20);
        n_cmp++;
        if (got_err !== 1'b0) begin
            n_bad++;
            $display("FAIL period_write_err: err=%b want 0", got_err);
        end
        rd(10'h118);
        n_cmp++;
        if (got_rd !== 32'h0) begin
            n_bad++;
            $display("FAIL period_reads_zero: PERIOD=%h want 00000000", got_rd);
        end
        wr(10'h11C, 32'd1);
        rd(10'h11C);
        n_cmp++;
        if (got_rd !== 32'h0) begin
            n_bad++;
            $display("FAIL cfg_reads_zero: CFG=%h want 00000000", got_rd);
        end
        wr(10'h014, 32'h2);
        wr(10'h000, 32'h1);
        idle(50);
        n_cmp++;
        if (intr !== 1'b0) begin
            n_bad++;
            $display("FAIL oneshot_pre: intr=%b want 0", intr);
        end
        idle(1);
        n_cmp++;
        if (intr !== 1'b1) begin
            n_bad++;
            $display("FAIL oneshot_hit: intr=%b want 1", intr);
        end
        idle(30);
        wr(10'h010, 32'h2);
        n_cmp++;
        if (intr !== 1'b1) begin
            n_bad++;
            $display("FAIL oneshot_sticky: intr=%b want 1", intr);
        end
        rd(10'h110);
        n_cmp++;
        if (got_rd !== 32'd50) begin
            n_bad++;
            $display("FAIL oneshot_cmp: CMP_LO=%0d want 50", got_rd);
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        be    = '0;
        addr  = '0;
        wdata = '0;
        @(negedge clk);
        test_reset();
        test_prescale();
        test_compare();
        test_back_to_back();
`ifdef TIMER_MULTI_PERIODIC_EN
        test_periodic();
        test_wrap();
`else
        test_oneshot_only();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
